montgomery_mul_param: RTL and testbench
=======================================

Name: montgomery_mul_param

Overview:
- Parametrised successor to the fixed 255-bit bit-serial Montgomery multiplier.
- Computes a*b*2^-WIDTH mod N for any width, with a runtime modulus.
- Consumes D bits of a per cycle by unrolling D radix-2 steps.
- Uses valid/ready handshakes on both sides so it can sit in the field-arithmetic datapath behind a scheduler and stall on backpressure.

Parameters:
- WIDTH, 255, operand/modulus width in bits (>=4).
- D, 1, radix-2 iterations per clock cycle (1..WIDTH).
- MOD, 2^255-19, fixed modulus, used only with MONT_FIXED_MOD_EN.

Ports:
- i_clk  in  1  clock; the block uses one clock.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_valid  in  1  operand request valid.
- o_ready  out  1  block can accept a request.
- i_a  in  WIDTH  multiplicand; required a < N.
- i_b  in  WIDTH  multiplier; required b < N.
- i_n  in  WIDTH  modulus; must be odd.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  WIDTH  a*b*2^-WIDTH mod N, fully reduced to [0, N).
- o_err  out  1  qualifies o_valid; latched modulus was even.

Behaviour:
- Reset (i_rst_n low at an edge):
  - State goes to S_IDLE; all registers clear.
  - o_valid=0, o_result=0, o_err=0, o_ready=1 after the edge.
  - Reset mid-operation abandons the operation; no o_valid is produced.
- o_ready = (state==S_IDLE), registered-state decode.
- Accept on i_valid&&o_ready:
  - Latch a, b and N (N from i_n, or MOD under the macro).
  - Clear accumulator m (WIDTH+2 bits) and the iteration counter.
  - Go to S_CALC.
- S_CALC, per cycle: apply D steps in sequence, for iteration index k = cnt*D + j, j=0..D-1.
  - t = a[k] ? m+b : m; t = t[0] ? t+N : t; m = t>>1.
  - Steps with k >= WIDTH are pass-through, so the last cycle handles WIDTH mod D bits when nonzero.
  - Executes exactly C = ceil(WIDTH/D) cycles, then goes to S_SUB.
- S_SUB: o_result <= (m >= N) ? m-N : m (low WIDTH bits); o_valid <= 1; go to S_DONE.
- Even latched N:
  - CALC/SUB still run the full length, so latency is fixed.
  - In S_SUB, o_result <= 0 and o_err <= 1.
- S_DONE:
  - o_valid, o_result and o_err are held stable until i_ready.
  - On o_valid&&i_ready: o_valid <= 0, o_err <= 0, go to S_IDLE.
  - o_result keeps its last value after the handshake.
- Latency: o_valid rises C+1 cycles after the accepting edge; D=1, WIDTH=255 gives 256.
- No same-cycle turnaround: o_ready rises the cycle after the result handshake. Issue interval is therefore C+3 cycles minimum.
- i_valid while busy is ignored; the requester must hold the request until o_ready.
- Input changes on i_a/i_b/i_n after accept have no effect.
- Width rules:
  - With a,b < N < 2^WIDTH, m stays < 2N, so WIDTH+2 bits never overflow.
  - a or b >= N is outside contract; the output is undefined but the handshake timing is unchanged.

Optional Feature:
- Macro MONT_FIXED_MOD_EN.
- Defined:
  - i_n is ignored (may be left unconnected) and N = MOD is a constant.
  - No N register is synthesised.
  - o_err is tied to 0 (MOD must be odd; elaboration check).
- Undefined: N is taken from i_n at accept and registered, as described above.

Test Plan:
- WIDTH=8, D=1, N=239; a=5, b=7 -> o_result=227, o_err=0, o_valid exactly 9 cycles after the accept edge.
- WIDTH=8, D=3, N=239; a=b=238, then a=b=1 -> both results 225, latency 4 cycles each, o_ready low throughout each operation.
- WIDTH=8, D=1, N=239; a=0, b=200 -> 0. Then hold i_ready low 5 cycles after o_valid -> o_valid/o_result stable, o_ready stays 0, and a concurrent i_valid is not accepted.
- WIDTH=8, N=238 (even); a=5, b=7 -> o_result=0, o_err=1, latency 9. The next request with N=239 gives 227 with o_err=0.
- Reset: i_rst_n low for 1 cycle at CALC cycle 4 -> no o_valid; o_ready=1 the next cycle; a fresh a=5, b=7 gives 227.
- MONT_FIXED_MOD_EN defined, MOD=239, WIDTH=8; i_n=0, a=5, b=7 -> o_result=227, o_err=0.

Source files
------------

// File: rtl/montgomery_mul_param.sv
// -----------------------------------------------------------------------------
// montgomery_mul_param
//
// Purpose:
//   Montgomery multiplier computing o_result = a * b * 2^-WIDTH mod N.
//   Processes D bits of the multiplicand per clock by unrolling D radix-2
//   steps. Uses a valid/ready handshake on both the request and result
//   sides, so it can stall on downstream backpressure.
//
// Parameters:
//   WIDTH  operand / modulus width in bits (>= 4)
//   D      radix-2 iterations per clock (1..WIDTH)
//   The fixed modulus parameter applies only when MONT_FIXED_MOD_EN is
//   defined.
//
// Configuration macro:
//   MONT_FIXED_MOD_EN  when defined, i_n is ignored and N = MOD. No modulus
//                      register is built, and o_err is tied low. MOD must be
//                      odd, which elaboration checks.
//
// Ports:
//   i_clk     clock
//   i_rst_n   synchronous active-low reset
//   i_valid   request valid          o_ready   block idle, can accept
//   i_a       multiplicand (< N)     i_b       multiplier (< N)
//   i_n       modulus (odd)
//   o_valid   result valid           i_ready   downstream accepts result
//   o_result  a*b*2^-WIDTH mod N, fully reduced to [0, N)
//   o_err     qualifies o_valid: the latched modulus was even
//
// Timing:
//   C = ceil(WIDTH/D). o_valid rises C+1 cycles after the accepting edge.
//   o_ready returns the cycle after the result handshake.
// -----------------------------------------------------------------------------
module montgomery_mul_param #(
  parameter int               WIDTH = 255,
  parameter int               D     = 1,
  parameter logic [WIDTH-1:0] MOD   = {WIDTH{1'b1}} - WIDTH'(18)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  // Number of CALC cycles, and the number of live steps in the final cycle.
  // The final cycle has fewer live steps when WIDTH is not a multiple of D.
  localparam int C          = (WIDTH + D - 1) / D;
  localparam int LAST_STEPS = WIDTH - (C - 1) * D;
  localparam int CNT_W      = (C > 1) ? $clog2(C) : 1;
  // The accumulator stays below 2N. Intermediate sums stay below 4N,
  // so two guard bits are enough.
  localparam int MW         = WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 4) begin : g_chk_width
    $fatal(1, "montgomery_mul_param: WIDTH must be >= 4");
  end
  if ((D < 1) || (D > WIDTH)) begin : g_chk_d
    $fatal(1, "montgomery_mul_param: D must be in 1..WIDTH");
  end

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [MW-1:0]    m_q,      m_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] n_eff;

`ifdef MONT_FIXED_MOD_EN
  if (MOD[0] == 1'b0) begin : g_chk_mod
    $fatal(1, "montgomery_mul_param: MOD must be odd");
  end

  // Modulus is a constant. The i_n port is deliberately left unused.
  logic unused_n;
  assign unused_n = ^i_n;
  assign n_eff    = MOD;
  assign o_err    = 1'b0;
`else
  logic [WIDTH-1:0] n_q, n_d;
  logic             err_q, err_d;

  assign n_eff = n_q;
  assign o_err = err_q;
`endif

  logic             last_cycle;
  logic [MW-1:0]    m_step;
  logic             m_ge_n;

  assign last_cycle = (cnt_q == CNT_W'(C - 1));
  assign m_ge_n     = (m_q >= {2'b00, n_eff});

  // ---------------------------------------------------------------------------
  // Unrolled radix-2 Montgomery steps for one CALC cycle.
  // The multiplicand register is shifted right by D each cycle,
  // so step j always consumes a_q[j], which is bit k = cnt*D + j of the
  // original operand.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [MW-1:0] t;
    // NOTE: blocking assignments here chain the D steps combinationally
    // within one cycle. Each step reads the value the previous step just wrote.
    t      = '0;
    m_step = m_q;
    for (int j = 0; j < D; j++) begin
      // Steps beyond bit WIDTH-1 in the final cycle are pass-through.
      if (!last_cycle || (j < LAST_STEPS)) begin
        t      = a_q[j] ? (m_step + {2'b00, b_q}) : m_step;
        t      = t[0]   ? (t + {2'b00, n_eff})    : t;
        m_step = t >> 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every *_d gets its hold value first. Then no path through the
    // case statement leaves a signal unassigned, so no latch is inferred.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    result_d = result_q;
`ifndef MONT_FIXED_MOD_EN
    n_d      = n_q;
    err_d    = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
`ifndef MONT_FIXED_MOD_EN
          n_d     = i_n;
`endif
          m_d     = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        m_d   = m_step;
        a_d   = a_q >> D;
        cnt_d = cnt_q + 1'b1;
        if (last_cycle) begin
          state_d = S_SUB;
        end
      end

      S_SUB: begin
        // m < 2N, so a single conditional subtraction fully reduces it.
        // The reduced value fits in WIDTH bits, so subtracting on the low
        // WIDTH bits alone gives the same answer.
        result_d = m_ge_n ? (m_q[WIDTH-1:0] - n_eff) : m_q[WIDTH-1:0];
`ifndef MONT_FIXED_MOD_EN
        if (!n_q[0]) begin
          result_d = '0;
          err_d    = 1'b1;
        end
`endif
        valid_d = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        // Hold the result until downstream takes it. o_result deliberately
        // keeps its value after the handshake.
        if (i_ready) begin
          valid_d = 1'b0;
`ifndef MONT_FIXED_MOD_EN
          err_d   = 1'b0;
`endif
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: the operand and accumulator registers are cleared along with
      // the control state. After reset the outputs show 0, and no stale
      // operand data survives an abandoned operation.
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
`ifndef MONT_FIXED_MOD_EN
      n_q      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
`ifndef MONT_FIXED_MOD_EN
      n_q      <= n_d;
      err_q    <= err_d;
`endif
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_montgomery_mul_param.sv
// -----------------------------------------------------------------------------
// tb_montgomery_mul_param
//
// Self-checking bench for montgomery_mul_param. Three 8-bit instances with
// D = 1, 3 and 8 share one clock and reset. Directed vectors come from a
// table. Randomised operations are compared against a modular-arithmetic
// reference: a*b*R^-1 mod N, where R^-1 is found by search.
// If MONT_FIXED_MOD_EN is defined, the modulus is fixed at 239.
// -----------------------------------------------------------------------------
module tb_montgomery_mul_param;

  localparam int NI = 3;
  localparam int W  = 8;
  localparam int TIMEOUT = 100;

`ifdef MONT_FIXED_MOD_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // C+1 for D = 1, 3, 8 at WIDTH = 8.
  int exp_lat_of [NI] = '{9, 4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         valid_in  [NI];
  logic         ready_out [NI];
  logic         valid_out [NI];
  logic         ready_in  [NI];
  logic         err_out   [NI];
  logic [W-1:0] a_in      [NI];
  logic [W-1:0] b_in      [NI];
  logic [W-1:0] n_in      [NI];
  logic [W-1:0] res_out   [NI];

  int errors = 0;
  int checks = 0;

  montgomery_mul_param #(.WIDTH(W), .D(1), .MOD(8'd239)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid_in[0]), .o_ready(ready_out[0]),
    .i_a(a_in[0]), .i_b(b_in[0]), .i_n(n_in[0]),
    .o_valid(valid_out[0]), .i_ready(ready_in[0]),
    .o_result(res_out[0]), .o_err(err_out[0])
  );

  montgomery_mul_param #(.WIDTH(W), .D(3), .MOD(8'd239)) u_d3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid_in[1]), .o_ready(ready_out[1]),
    .i_a(a_in[1]), .i_b(b_in[1]), .i_n(n_in[1]),
    .o_valid(valid_out[1]), .i_ready(ready_in[1]),
    .o_result(res_out[1]), .o_err(err_out[1])
  );

  montgomery_mul_param #(.WIDTH(W), .D(8), .MOD(8'd239)) u_d8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid_in[2]), .o_ready(ready_out[2]),
    .i_a(a_in[2]), .i_b(b_in[2]), .i_n(n_in[2]),
    .o_valid(valid_out[2]), .i_ready(ready_in[2]),
    .o_result(res_out[2]), .o_err(err_out[2])
  );

  typedef struct {
    int    inst;
    int    a;
    int    b;
    int    n;
    int    res;
    int    err;
    int    hold;
    string name;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a*b*2^-8 mod n, plain modular arithmetic.
  function automatic int mont_ref(input int a, input int b, input int n);
    if ((n % 2) == 0) return 0;
    for (int x = 0; x < n; x++) begin
      if (((x * 256) % n) == 1) return ((a * b) % n) * x % n;
    end
    return -1;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete request/result transaction on instance inst.
  // hold: number of extra cycles i_ready is held low after o_valid. During
  // those cycles a competing request is presented and must be ignored.
  task automatic run_op(input int inst, input int a, input int b, input int n,
                        input int exp_res, input int exp_err, input int hold,
                        input string name);
    int lat;
    bit busy_ok;
    bit stable_ok;
    @(negedge clk);
    check({name, ".ready_before"}, 64'(ready_out[inst]), 64'd1);
    valid_in[inst] = 1'b1;
    a_in[inst]     = W'(a);
    b_in[inst]     = W'(b);
    n_in[inst]     = W'(n);
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs after accept. The latched copy must be used.
    valid_in[inst] = 1'b0;
    a_in[inst]     = W'($urandom);
    b_in[inst]     = W'($urandom);
    n_in[inst]     = W'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    while ((valid_out[inst] !== 1'b1) && (lat < TIMEOUT)) begin
      if (ready_out[inst] !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, ".latency"}, 64'(lat), 64'(exp_lat_of[inst]));
    if (valid_out[inst] !== 1'b1) begin
      $display("FAIL %s.timeout: no o_valid within %0d cycles", name, TIMEOUT);
      errors++;
      checks++;
      pulse_reset();
      return;
    end
    check({name, ".busy_ready"}, 64'(busy_ok), 64'd1);
    check({name, ".result"}, 64'(res_out[inst]), 64'(exp_res));
    check({name, ".err"}, 64'(err_out[inst]), 64'(exp_err));

    stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      valid_in[inst] = 1'b1;
      a_in[inst]     = 8'd5;
      b_in[inst]     = 8'd7;
      n_in[inst]     = 8'd239;
      @(posedge clk);
      @(negedge clk);
      if ((valid_out[inst] !== 1'b1) || (res_out[inst] !== W'(exp_res)) ||
          (err_out[inst] !== 1'(exp_err)) || (ready_out[inst] !== 1'b0))
        stable_ok = 1'b0;
    end
    valid_in[inst] = 1'b0;
    if (hold > 0) check({name, ".hold_stable"}, 64'(stable_ok), 64'd1);

    ready_in[inst] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_in[inst] = 1'b0;
    check({name, ".post_valid"}, 64'(valid_out[inst]), 64'd0);
    check({name, ".post_ready"}, 64'(ready_out[inst]), 64'd1);
    check({name, ".post_err"}, 64'(err_out[inst]), 64'd0);
    check({name, ".post_result"}, 64'(res_out[inst]), 64'(exp_res));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_ref;
    int  a;
    int  b;
    int  n;
    bit  saw_valid;

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      valid_in[i] = 1'b0;
      ready_in[i] = 1'b0;
      a_in[i]     = '0;
      b_in[i]     = '0;
      n_in[i]     = '0;
    end

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset%0d.ready", i),  64'(ready_out[i]), 64'd1);
      check($sformatf("reset%0d.valid", i),  64'(valid_out[i]), 64'd0);
      check($sformatf("reset%0d.result", i), 64'(res_out[i]),   64'd0);
      check($sformatf("reset%0d.err", i),    64'(err_out[i]),   64'd0);
    end
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    vecs.push_back('{0,   5,   7, 239, 227, 0, 0, "d1_basic"});
    vecs.push_back('{1, 238, 238, 239, 225, 0, 0, "d3_max"});
    vecs.push_back('{1,   1,   1, 239, 225, 0, 0, "d3_one"});
    vecs.push_back('{0,   0, 200, 239,   0, 0, 5, "d1_zero_hold"});
    if (FIXED) vecs.push_back('{0, 5, 7,   0, 227, 0, 0, "d1_fixed_mod"});
    else       vecs.push_back('{0, 5, 7, 238,   0, 1, 0, "d1_even_n"});
    vecs.push_back('{0,   5,   7, 239, 227, 0, 0, "d1_after_even"});
    vecs.push_back('{2,   5,   7, 239, 227, 0, 1, "d8_single_cycle"});
    vecs.push_back('{2, 238,   1, 239, 238 * 225 % 239, 0, 0, "d8_edge"});

    foreach (vecs[v]) begin
      run_op(vecs[v].inst, vecs[v].a, vecs[v].b, vecs[v].n,
             vecs[v].res, vecs[v].err, vecs[v].hold, vecs[v].name);
    end

    // ---------------- reset during CALC ----------------
    @(negedge clk);
    valid_in[0] = 1'b1;
    a_in[0] = 8'd5; b_in[0] = 8'd7; n_in[0] = 8'd239;
    @(posedge clk);                 // accept
    @(negedge clk);
    valid_in[0] = 1'b0;
    repeat (3) @(posedge clk);      // CALC cycles 1..3
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);                 // CALC cycle 4 edge sees reset
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset.ready", 64'(ready_out[0]), 64'd1);
    check("midreset.valid", 64'(valid_out[0]), 64'd0);
    saw_valid = 1'b0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_out[0] !== 1'b0) saw_valid = 1'b1;
    end
    check("midreset.no_valid", 64'(saw_valid), 64'd0);
    run_op(0, 5, 7, 239, 227, 0, 0, "midreset.fresh");

    // ---------------- randomised against the reference model ----------------
    for (int inst = 0; inst < NI; inst++) begin
      for (int r = 0; r < 15; r++) begin
        if (FIXED)                            n = 239;
        else if ($urandom_range(7, 0) == 0)   n = 2 * $urandom_range(127, 2);
        else                                  n = 2 * $urandom_range(127, 1) + 1;
        a     = $urandom_range(n - 1, 0);
        b     = $urandom_range(n - 1, 0);
        n_ref = FIXED ? 239 : n;
        run_op(inst, a, b, (FIXED ? int'($urandom_range(255, 0)) : n),
               mont_ref(a, b, n_ref), ((n_ref % 2) == 0) ? 1 : 0,
               $urandom_range(2, 0),
               $sformatf("rand_i%0d_%0d(a=%0d,b=%0d,n=%0d)", inst, r, a, b, n_ref));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
